risc_core_mc: RTL

Parametrised multi-cycle successor of the fixed 16-bit RISC processor top, combining control unit and execution unit in one block. Runs a fetch/decode/execute/memory state machine over a single shared memory port with a req/ack handshake, so slow memories insert wait states. Adds a configurable data width, a configurable reset vector, conditional PC-relative branches and a HALT state. Sits between the board-level memory/IO wrapper and the LED status display.

---
 rtl/risc_pkg.sv | 77 +++++++
 rtl/risc_alu.sv | 54 +++++
 rtl/risc_core_mc.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared types and constants for the multi-cycle RISC core:
//               opcode and state enums, branch-condition codes, instruction
//               field positions and LED_Status bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_LDI  = 4'h8,
    OP_LD   = 4'h9,
    OP_ST   = 4'hA,
    OP_JMP  = 4'hB,
    OP_BR   = 4'hC,
    OP_MOV  = 4'hD,
    OP_HLT0 = 4'hE,
    OP_HLT1 = 4'hF
  } opcode_e;

  // Encoding is visible on LED_Status, so values are fixed.
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  // Branch conditions, carried in the W field of a BR instruction.
  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_N      = 3'b010;
  localparam logic [2:0] COND_C      = 3'b011;
  localparam logic [2:0] COND_NZ     = 3'b100;

  // Instruction field positions.
  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int W_MSB    = 11;
  localparam int W_LSB    = 9;
  localparam int R_MSB    = 8;
  localparam int R_LSB    = 6;
  localparam int S_MSB    = 5;
  localparam int S_LSB    = 3;
  localparam int IMM9_MSB = 8;
  localparam int IMM6_MSB = 5;

  // LED_Status bit positions.
  localparam int LED_HALTED    = 7;
  localparam int LED_STATE_MSB = 6;
  localparam int LED_STATE_LSB = 4;
  localparam int LED_N         = 2;
  localparam int LED_Z         = 1;
  localparam int LED_C         = 0;

  // Opcodes whose result updates N, Z and C.
  function automatic logic is_flag_op(input opcode_e op);
    logic r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: r = 1'b1;
      default:                                              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/risc_alu.sv
`default_nettype none
// ============================================================================
// Module      : risc_alu
// Description : Combinational ALU for the RISC core.
//   a, b    in  DATA_W  operands (R and S)
//   op      in  4       opcode
//   result  out DATA_W  operation result
//   n, z, c out 1       negative, zero, carry/no-borrow/shifted-out bit
// Revision    : 1.0 - initial release
// ============================================================================
module risc_alu
  import risc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_e           op,
  output logic [DATA_W-1:0] result,
  output logic              n,
  output logic              z,
  output logic              c
);

  always_comb begin
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: {c, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        c      = (a >= b);          // carry means "no borrow"
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        c      = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        c      = a[0];
      end
      OP_MOV: result = a;
      default: ;
    endcase
  end

  assign n = result[DATA_W-1];
  assign z = (result == '0);

endmodule
`default_nettype wire

// File: rtl/risc_core_mc.sv
`default_nettype none
// ============================================================================
// Module      : risc_core_mc
// Description : Multi-cycle 16-bit-instruction RISC core with a single shared
//               req/ack memory port (FETCH/DECODE/EXECUTE/MEM/HALT).
//   clk        in  1       clock, rising edge
//   reset      in  1       asynchronous, active-low reset
//   mem_req    out 1       memory access request
//   mem_we     out 1       1 = write (valid with mem_req)
//   Address    out ADDR_W  memory address
//   RISC_Out   out DATA_W  write data
//   RISC_In    in  DATA_W  read data, sampled when mem_ack = 1
//   mem_ack    in  1       access completes this cycle
//   LED_Status out 8       {halted, state[2:0], 0, N, Z, C}
// Parameters  : DATA_W >= 16, ADDR_W <= DATA_W, RESET_PC.
// Revision    : 1.0 - initial release
// ============================================================================
module risc_core_mc
  import risc_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] RISC_Out,
  input  logic [DATA_W-1:0] RISC_In,
  input  logic              mem_ack,
  output logic [7:0]        LED_Status
);

  state_e            state_q, state_d;
  logic              started_q, started_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              n_q, n_d, z_q, z_d, c_q, c_d;
  logic [DATA_W-1:0] rf_q [8];
  logic [DATA_W-1:0] rf_d [8];

  opcode_e           op;
  logic [2:0]        fld_w, fld_r, fld_s;
  logic [DATA_W-1:0] alu_result;
  logic              alu_n, alu_z, alu_c;
  logic              br_taken;

  assign op    = opcode_e'(ir_q[OP_MSB:OP_LSB]);
  assign fld_w = ir_q[W_MSB:W_LSB];
  assign fld_r = ir_q[R_MSB:R_LSB];
  assign fld_s = ir_q[S_MSB:S_LSB];

  risc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op),
    .result (alu_result),
    .n      (alu_n),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_comb begin
    case (fld_w)
      COND_ALWAYS: br_taken = 1'b1;
      COND_Z:      br_taken = z_q;
      COND_N:      br_taken = n_q;
      COND_C:      br_taken = c_q;
      COND_NZ:     br_taken = !z_q;
      default:     br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    // started_q gates the very first fetch so mem_req stays low during
    // reset and rises on the first edge after release.
    started_d = 1'b1;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    n_d       = n_q;
    z_d       = z_q;
    c_d       = c_q;
    rf_d      = rf_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    Address   = pc_q;
    RISC_Out  = '0;

    case (state_q)
      ST_FETCH: begin
        mem_req = started_q;
        if (started_q && mem_ack) begin
          ir_d    = RISC_In[15:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d     = rf_q[fld_r];
        b_d     = rf_q[fld_s];
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        if (is_flag_op(op)) begin
          rf_d[fld_w] = alu_result;
          n_d         = alu_n;
          z_d         = alu_z;
          c_d         = alu_c;
        end
        case (op)
          OP_MOV:         rf_d[fld_w] = alu_result;
          OP_LDI:         rf_d[fld_w] = {{(DATA_W-9){ir_q[IMM9_MSB]}}, ir_q[IMM9_MSB:0]};
          OP_LD, OP_ST:   state_d = ST_MEM;
          OP_JMP:         pc_d = a_q[ADDR_W-1:0];
          OP_BR: begin
            // pc_q already points past the branch.
            if (br_taken) begin
              pc_d = pc_q + {{(ADDR_W-6){ir_q[IMM6_MSB]}}, ir_q[IMM6_MSB:0]};
            end
          end
          OP_HLT0, OP_HLT1: state_d = ST_HALT;
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op == OP_ST);
        Address = a_q[ADDR_W-1:0];
        if (op == OP_ST) begin
          RISC_Out = b_q;
        end
        if (mem_ack) begin
          if (op == OP_LD) begin
            rf_d[fld_w] = RISC_In;
          end
          state_d = ST_FETCH;
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      started_q <= 1'b0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      rf_q      <= '{default: '0};
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      n_q       <= n_d;
      z_q       <= z_d;
      c_q       <= c_d;
      rf_q      <= rf_d;
    end
  end

  always_comb begin
    LED_Status                              = '0;
    LED_Status[LED_HALTED]                  = (state_q == ST_HALT);
    LED_Status[LED_STATE_MSB:LED_STATE_LSB] = state_q;
    LED_Status[LED_N]                       = n_q;
    LED_Status[LED_Z]                       = z_q;
    LED_Status[LED_C]                       = c_q;
  end

endmodule
`default_nettype wire
